serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/fa_cell.sv | 18 +
 rtl/serial_addsub.sv | 102 ++++++++++
 tb/tb_serial_addsub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder assembled from two half-adder stages and an OR of their carries.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic h1_s, h1_c, h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one result bit per cycle, LSB first, through a single full-adder cell.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co, last_bit;

  fa_cell u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign sum      = res;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at accept and the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= a;
          opb   <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          // On the MSB edge, carry still holds the carry into the MSB.
          if (last_bit) begin
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vector table, random ops against an arithmetic model,
// backpressure, input interference and mid-operation reset.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain unsigned/signed integer arithmetic. Returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
    int           sa, sb, r;
    logic [W-1:0] s;
    logic         c, v;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      s = ma - mb;
      c = (int'(ma) >= int'(mb));
      r = sa - sb;
    end else begin
      s = ma + mb;
      c = ((int'(ma) + int'(mb)) >= (2 ** W));
      r = sa + sb;
    end
    v = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    return {v, c, s};
  endfunction

  // Issue one request, wait for the result, optionally hold it under backpressure, then consume it.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input bit noise, input int hold,
                       output logic [W-1:0] rs, output logic rc, output logic rv, output int lat);
    int waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        check("in_ready low while busy", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    rs = sum; rc = cout; rv = overflow;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold sum stable", 32'(sum), 32'(rs));
      check("hold cout/ovf stable", {30'd0, cout, overflow}, {30'd0, rc, rv});
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready after consume", 32'(in_ready), 32'd1);
    check("out_valid after consume", 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0] r_sum, ra, rb;
  logic         r_c, r_v, rsub;
  int           r_lat;
  logic [W+1:0] m;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    // Reset state, sampled while rst_n is still low.
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout/ovf", {30'd0, cout, overflow}, 32'd0);

    // Released mid-cycle; the first request below must be taken on the very next edge.
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, 0, r_sum, r_c, r_v, r_lat);
      check($sformatf("vec%0d sum", i), 32'(r_sum), 32'(vecs[i].e_sum));
      check($sformatf("vec%0d cout", i), 32'(r_c), 32'(vecs[i].e_cout));
      check($sformatf("vec%0d overflow", i), 32'(r_v), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d latency", i), 32'(r_lat), 32'(W));
    end

    // Random operations, every third one with the inputs churning while busy.
    for (int i = 0; i < 24; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rsub = 1'($urandom);
      m    = model(ra, rb, rsub);
      do_op(ra, rb, rsub, (i % 3) == 0, 0, r_sum, r_c, r_v, r_lat);
      check($sformatf("rand%0d result", i), {22'd0, r_v, r_c, r_sum}, {22'd0, m});
      check($sformatf("rand%0d latency", i), 32'(r_lat), 32'(W));
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 5, r_sum, r_c, r_v, r_lat);
    check("backpressure result", {22'd0, r_v, r_c, r_sum}, {22'd0, 1'b1, 1'b0, 8'h80});

    // Interference on a directed case.
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 0, r_sum, r_c, r_v, r_lat);
    check("interference result", {22'd0, r_v, r_c, r_sum}, {22'd0, 1'b1, 1'b1, 8'h7F});
    check("interference latency", 32'(r_lat), 32'(W));

    // Reset in the middle of RUN discards the operation.
    a = 8'h3C; b = 8'h5A; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", 32'(out_valid), 32'd0);
    check("mid-run reset in_ready", 32'(in_ready), 32'd1);
    check("mid-run reset outputs", {23'd0, cout, overflow, sum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no result after reset", 32'(out_valid), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, r_sum, r_c, r_v, r_lat);
    check("post-reset sum", 32'(r_sum), 32'h02);
    check("post-reset latency", 32'(r_lat), 32'(W));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
